// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: a - b computed LSB first, one bit per clock,
// with the difference and final borrow presented in a separate output register.
module serial_sub #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             borrow
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             load_c, last_c, bit_c, br_c;

  // Next-state decode and the single-bit ripple-borrow cell
  always_comb begin
    state_next = state;
    load_c     = 1'b0;
    last_c     = 1'b0;
    bit_c      = a_sh[0] ^ b_sh[0] ^ br;
    br_c       = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    unique case (state)
      IDLE: begin
        if (start) begin
          load_c     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt == CW'(WIDTH - 1)) begin
          last_c     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load_c     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; busy/done are flopped from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == RUN);
      done  <= (state_next == DONE);
    end
  end

  // Operand shifters, working result register and the held output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      d      <= '0;
      borrow <= 1'b0;
    end else if (load_c) begin
      a_sh <= a;
      b_sh <= b;
      r_sh <= '0;
      br   <= 1'b0;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      r_sh <= {bit_c, r_sh[WIDTH-1:1]};
      br   <= br_c;
      cnt  <= cnt + CW'(1);
      if (last_c) begin
        d      <= {bit_c, r_sh[WIDTH-1:1]};
        borrow <= br_c;
      end
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub at WIDTH=4 and WIDTH=8: expected results are
// queued at issue and compared when done pulses.
module tb_serial_sub;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start4, start8;
  logic [3:0] a4, b4, d4;
  logic [7:0] a8, b8, d8;
  logic       busy4, done4, borrow4;
  logic       busy8, done8, borrow8;

  logic [4:0] q4[$];
  logic [8:0] q8[$];
  logic [4:0] e4;
  logic [8:0] e8;
  logic [3:0] last_d4;
  int         done_cnt4 = 0;
  int         n_chk = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  serial_sub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .d(d4), .borrow(borrow4)
  );

  serial_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .d(d8), .borrow(borrow8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Pop and compare on every done pulse
  always @(negedge clk) begin
    if (done4) begin
      done_cnt4++;
      check("q4_has_entry", 32'(q4.size() != 0), 32'd1);
      if (q4.size() != 0) begin
        e4 = q4.pop_front();
        check("d4", 32'(d4), 32'(e4[3:0]));
        check("borrow4", 32'(borrow4), 32'(e4[4]));
      end
    end
    if (done8) begin
      check("q8_has_entry", 32'(q8.size() != 0), 32'd1);
      if (q8.size() != 0) begin
        e8 = q8.pop_front();
        check("d8", 32'(d8), 32'(e8[7:0]));
        check("borrow8", 32'(borrow8), 32'(e8[8]));
      end
    end
  end

  // One WIDTH=4 operation; mid=1 pulses start with junk operands two cycles into RUN
  task automatic op4(input logic [3:0] ta, input logic [3:0] tb_, input bit mid);
    int n;
    start4 = 1'b1; a4 = ta; b4 = tb_;
    q4.push_back({ta < tb_, 4'(ta - tb_)});
    @(negedge clk);
    start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
    n = 1;
    while (!done4 && n < 20) begin
      check("busy4", 32'(busy4), 32'd1);
      check("hold_d4", 32'(d4), 32'(last_d4));
      start4 = mid && (n == 2);
      @(negedge clk);
      n++;
    end
    start4 = 1'b0;
    check("latency4", 32'(n), 32'd5);
    last_d4 = 4'(ta - tb_);
  endtask

  task automatic op8(input logic [7:0] ta, input logic [7:0] tb_);
    int n;
    start8 = 1'b1; a8 = ta; b8 = tb_;
    q8.push_back({ta < tb_, 8'(ta - tb_)});
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    n = 1;
    while (!done8 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("latency8", 32'(n), 32'd9);
  endtask

  initial begin
    int c0;
    logic [3:0] xa, xb, xd;
    rst_n = 1'b0; start4 = 1'b0; start8 = 1'b0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0; last_d4 = '0;
    #1;
    check("rst_busy", 32'(busy4), 32'd0);
    check("rst_done", 32'(done4), 32'd0);
    check("rst_d", 32'(d4), 32'd0);
    check("rst_borrow", 32'(borrow4), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors, issued back-to-back from DONE
    op4(4'b0110, 4'b1110, 1'b0);
    op4(4'b1110, 4'b0110, 1'b0);
    op4(4'b0000, 4'b0001, 1'b0);
    op4(4'b1010, 4'b1010, 1'b0);
    @(negedge clk);
    check("done_one_cycle", 32'(done4), 32'd0);
    check("idle_busy", 32'(busy4), 32'd0);
    check("idle_hold_d", 32'(d4), 32'(last_d4));

    // start during RUN is ignored
    c0 = done_cnt4;
    op4(4'h3, 4'h5, 1'b1);
    repeat (4) @(negedge clk);
    check("mid_start_done_cnt", 32'(done_cnt4 - c0), 32'd1);

    // start held high: one done every 5 cycles
    start4 = 1'b1;
    xd = '0;
    for (int k = 0; k < 3; k++) begin
      xa = 4'($urandom); xb = 4'($urandom); xd = 4'(xa - xb);
      a4 = xa; b4 = xb;
      q4.push_back({xa < xb, xd});
      for (int n = 1; n <= 5; n++) begin
        @(negedge clk);
        check("b2b_done", 32'(done4), 32'(n == 5));
      end
    end
    start4 = 1'b0;
    last_d4 = xd;
    @(negedge clk);
    check("b2b_idle", 32'(busy4 | done4), 32'd0);

    // Ensure nonzero held result, then reset mid-RUN between edges
    op4(4'h9, 4'h2, 1'b0);
    @(negedge clk);
    start4 = 1'b1; a4 = 4'hC; b4 = 4'h3;
    @(negedge clk);
    start4 = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0; start4 = 1'b1;
    #1;
    check("abort_busy", 32'(busy4), 32'd0);
    check("abort_done", 32'(done4), 32'd0);
    check("abort_d", 32'(d4), 32'd0);
    check("abort_borrow", 32'(borrow4), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("rst_ignores_start", 32'(busy4), 32'd0);
    rst_n = 1'b1; start4 = 1'b0; last_d4 = '0;
    repeat (3) @(negedge clk);
    check("abort_no_done", 32'(done4), 32'd0);
    op4(4'hC, 4'h3, 1'b0);
    @(negedge clk);

    // Exhaustive WIDTH=4 sweep with random idle gaps
    for (int i = 0; i < 256; i++) begin
      op4(4'(i >> 4), 4'(i), 1'b0);
      if ($urandom_range(1) == 1) @(negedge clk);
    end
    @(negedge clk);

    // WIDTH=8 corners and random pairs
    op8(8'h00, 8'hFF);
    op8(8'hFF, 8'hFF);
    op8(8'hFF, 8'h00);
    for (int i = 0; i < 40; i++) begin
      op8(8'($urandom), 8'($urandom));
      if ($urandom_range(1) == 1) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("q4_drained", 32'(q4.size()), 32'd0);
    check("q8_drained", 32'(q8.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction; sampled on rising clk.
REQ-005 The block SHALL have port a, input, WIDTH bits: minuend, unsigned, captured when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH bits: subtrahend, unsigned, captured when start is accepted.
REQ-007 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-009 The block SHALL have port d, output, WIDTH bits: difference, (a - b) mod 2^WIDTH.
REQ-010 The block SHALL have port borrow, output, 1 bit: final borrow out; 1 iff a < b unsigned.

Function
REQ-011 The block SHALL use a three-state FSM with states IDLE, RUN and DONE.
REQ-012 In IDLE or DONE, start=1 at a rising edge SHALL latch a and b, clear the internal borrow flop and the bit counter, and enter RUN; that edge is E0.
REQ-013 In RUN, each edge SHALL process one bit, LSB first, in ripple-borrow fashion: d_i = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-014 Result bits SHALL shift into a WIDTH-bit result register from the MSB end, so that after WIDTH RUN edges bit i sits at d[i].
REQ-015 RUN SHALL last exactly WIDTH cycles; the edge processing bit WIDTH-1 (E_WIDTH) SHALL enter DONE.
REQ-016 busy SHALL be 1 exactly while in RUN: from after E0 until E_WIDTH.
REQ-017 done SHALL be 1 exactly while in DONE, for one cycle after E_WIDTH.
REQ-018 The latency from the accepting edge to done high SHALL be WIDTH+1 clock cycles.
REQ-019 d and borrow SHALL update only at E_WIDTH and SHALL hold their values through IDLE until the next E_WIDTH.
REQ-020 During RUN, d and borrow SHALL keep the previous result; the working shift register is separate from the d output register.
REQ-021 DONE SHALL go to IDLE on the next edge when start=0, and to RUN (new operation) when start=1 (back-to-back).
REQ-022 start while in RUN SHALL be ignored; the latched operands SHALL NOT change mid-operation.
REQ-023 Changes on a or b after E0 SHALL NOT affect the result.
REQ-024 Equal operands SHALL give d=0 and borrow=0.

Reset
REQ-025 rst_n=0 SHALL immediately, without waiting for clk, force: state IDLE, busy=0, done=0, d=0, borrow=0, internal borrow=0, counter=0.
REQ-026 Reset asserted mid-RUN SHALL abort the operation with no done pulse; after release the block SHALL accept a new start normally.
REQ-027 While rst_n=0, start SHALL be ignored.

Verification
REQ-028 WIDTH=4, a=0110, b=1110, start for one cycle -> busy high 4 cycles, then done for 1 cycle with d=1000, borrow=1.
REQ-029 a=1110, b=0110 -> d=1000, borrow=0; a=0000, b=0001 -> d=1111, borrow=1; a=b=1010 -> d=0000, borrow=0.
REQ-030 start pulsed again 2 cycles into RUN with different operands -> ignored; result matches the first operands; done pulses once.
REQ-031 start held high continuously -> back-to-back operations, one done pulse every 5 cycles; d updates each time.
REQ-032 rst_n driven low mid-RUN, between clock edges -> outputs 0 at once, no done; a fresh start afterwards gives the correct result.
REQ-033 Random sweep of all 256 operand pairs (WIDTH=4) plus random pairs at WIDTH=8 -> d and borrow match a golden a-b model.
